// File: rtl/operand_fetch_if.sv
// rtl/operand_fetch_if.sv - decoder, register-bank and issue signals of the operand fetch stage
interface operand_fetch_if;
    logic        inValid;
    logic        inReady;
    logic [31:0] instrIn;
    logic [31:0] pcIn;
    logic [3:0]  rnAddr;
    logic [3:0]  rmAddr;
    logic [3:0]  rsAddr;
    logic [2:0]  useMask;

    logic        rbTrigger;
    logic [3:0]  rbAddr;
    logic        rbReady;
    logic [31:0] rbData;

    logic        outValid;
    logic        outReady;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [31:0] opC;
    logic [31:0] instrOut;
    logic [31:0] pcOut;

    modport slave (
        input  inValid, instrIn, pcIn, rnAddr, rmAddr, rsAddr, useMask,
        input  rbReady, rbData, outReady,
        output inReady, rbTrigger, rbAddr,
        output outValid, opA, opB, opC, instrOut, pcOut
    );

    modport master (
        output inValid, instrIn, pcIn, rnAddr, rmAddr, rsAddr, useMask,
        output rbReady, rbData, outReady,
        input  inReady, rbTrigger, rbAddr,
        input  outValid, opA, opB, opC, instrOut, pcOut
    );
endinterface

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - operand fetch stage reading Rn/Rm/Rs from a two-phase register bank
// R15 sources bypass the bank and return the latched PC plus PC_OFFSET.
module operand_fetch #(
    parameter int          WAIT_CYCLES = 3,
    parameter logic [31:0] PC_OFFSET   = 32'd8
) (
    input  logic           clk,
    input  logic           rst,
    operand_fetch_if.slave bus
);
    localparam int               CNT_W    = $clog2(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEL,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [31:0]      r_instr;
    logic [31:0]      r_pc;
    logic [3:0]       r_rn_addr;
    logic [3:0]       r_rm_addr;
    logic [3:0]       r_rs_addr;
    logic [2:0]       r_pending;
    logic [1:0]       r_sel;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_sync;
    logic             r_trigger;
    logic [3:0]       r_rb_addr;
    logic [31:0]      r_op_a;
    logic [31:0]      r_op_b;
    logic [31:0]      r_op_c;

    logic [1:0]       w_sel_idx;
    logic [3:0]       w_sel_addr;
    logic             w_ready_sync;
    logic             w_accept;
    logic             w_issue;
    logic             w_wr_en;
    logic [1:0]       w_wr_idx;
    logic [31:0]      w_wr_data;
    logic             w_in_ready;
    logic             w_out_valid;

    assign w_ready_sync = r_sync[1];

    // Lowest pending source wins: Rn, then Rm, then Rs.
    always_comb begin
        w_sel_idx  = 2'd0;
        w_sel_addr = r_rn_addr;
        if (r_pending[0]) begin
            w_sel_idx  = 2'd0;
            w_sel_addr = r_rn_addr;
        end else if (r_pending[1]) begin
            w_sel_idx  = 2'd1;
            w_sel_addr = r_rm_addr;
        end else if (r_pending[2]) begin
            w_sel_idx  = 2'd2;
            w_sel_addr = r_rs_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_issue      = 1'b0;
        w_wr_en      = 1'b0;
        w_wr_idx     = w_sel_idx;
        w_wr_data    = r_pc + PC_OFFSET;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.inValid) begin
                    w_accept     = 1'b1;
                    w_next_state = S_SEL;
                end
            end
            S_SEL: begin
                if (r_pending == 3'b000) begin
                    w_next_state = S_DONE;
                end else if (w_sel_addr == 4'd15) begin
                    w_wr_en = 1'b1;
                end else begin
                    w_issue      = 1'b1;
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                // No timeout: a bank that never answers stalls the stage.
                if (r_cnt == '0 && w_ready_sync) begin
                    w_wr_en      = 1'b1;
                    w_wr_idx     = r_sel;
                    w_wr_data    = bus.rbData;
                    w_next_state = S_SEL;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.outReady) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], bus.rbReady};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr   <= '0;
            r_pc      <= '0;
            r_rn_addr <= '0;
            r_rm_addr <= '0;
            r_rs_addr <= '0;
            r_pending <= '0;
            r_sel     <= '0;
            r_cnt     <= '0;
            r_trigger <= 1'b0;
            r_rb_addr <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_op_c    <= '0;
        end else begin
            if (w_accept) begin
                r_instr   <= bus.instrIn;
                r_pc      <= bus.pcIn;
                r_rn_addr <= bus.rnAddr;
                r_rm_addr <= bus.rmAddr;
                r_rs_addr <= bus.rsAddr;
                r_pending <= bus.useMask;
                r_op_a    <= '0;
                r_op_b    <= '0;
                r_op_c    <= '0;
            end

            // Address and trigger move together so the bank sees a stable address per toggle.
            if (w_issue) begin
                r_rb_addr <= w_sel_addr;
                r_trigger <= ~r_trigger;
                r_sel     <= w_sel_idx;
                r_cnt     <= CNT_LOAD;
            end else if (r_state == S_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            if (w_wr_en) begin
                case (w_wr_idx)
                    2'd0:    r_op_a <= w_wr_data;
                    2'd1:    r_op_b <= w_wr_data;
                    default: r_op_c <= w_wr_data;
                endcase
                r_pending[w_wr_idx] <= 1'b0;
            end
        end
    end

    assign bus.inReady   = w_in_ready;
    assign bus.outValid  = w_out_valid;
    assign bus.rbTrigger = r_trigger;
    assign bus.rbAddr    = r_rb_addr;
    assign bus.opA       = r_op_a;
    assign bus.opB       = r_op_b;
    assign bus.opC       = r_op_c;
    assign bus.instrOut  = r_instr;
    assign bus.pcOut     = r_pc;
endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - self-checking bench for operand_fetch
module tb_operand_fetch;
    localparam int          WAIT_CYCLES = 3;
    localparam logic [31:0] PC_OFFSET   = 32'd8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    operand_fetch_if bus ();

    operand_fetch #(
        .WAIT_CYCLES(WAIT_CYCLES),
        .PC_OFFSET  (PC_OFFSET)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] bank_mem [16];
    int          bank_delay = 0;
    logic [3:0]  trig_log [$];
    logic [3:0]  exp_addr [$];

    // Register bank: drops ready on every trigger toggle, re-raises it with data later.
    always @(bus.rbTrigger) begin
        logic [3:0] a;
        bus.rbReady = 1'b0;
        #1;
        a = bus.rbAddr;
        trig_log.push_back(a);
        if (bank_delay > 0) begin
            repeat (bank_delay) @(posedge clk);
            #1;
        end
        bus.rbData  = bank_mem[a];
        bus.rbReady = 1'b1;
    end

    task automatic model(input logic [31:0] pc, input logic [3:0] rn, rm, rs, input logic [2:0] mask,
                         output logic [31:0] ea, eb, ec, output int ecyc);
        logic [3:0]  a [3];
        logic [31:0] v [3];
        int n = 0;
        int p = 0;
        a[0] = rn; a[1] = rm; a[2] = rs;
        exp_addr.delete();
        for (int i = 0; i < 3; i++) begin
            v[i] = 32'd0;
            if (mask[i]) begin
                if (a[i] == 4'd15) begin
                    v[i] = pc + PC_OFFSET;
                    p++;
                end else begin
                    v[i] = bank_mem[a[i]];
                    exp_addr.push_back(a[i]);
                    n++;
                end
            end
        end
        ea = v[0]; eb = v[1]; ec = v[2];
        ecyc = 2 + n * (WAIT_CYCLES + 1) + p;
    endtask

    // Offers one instruction, returns the first cycle (accept edge = edge 0) with outValid high.
    task automatic send(input logic [31:0] instr, pc, input logic [3:0] rn, rm, rs,
                        input logic [2:0] mask, output int cyc);
        @(negedge clk);
        trig_log.delete();
        bus.instrIn = instr;
        bus.pcIn    = pc;
        bus.rnAddr  = rn;
        bus.rmAddr  = rm;
        bus.rsAddr  = rs;
        bus.useMask = mask;
        bus.inValid = 1'b1;
        @(posedge clk);
        #1 bus.inValid = 1'b0;
        cyc = 1;
        @(negedge clk);
        while (bus.outValid !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic consume;
        bus.outReady = 1'b1;
        @(posedge clk);
        #1 bus.outReady = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        #12;
        checks++; if (bus.inReady !== 1'b1) begin errors++; $display("FAIL reset_inReady: got %b expected 1", bus.inReady); end
        checks++; if (bus.outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid: got %b expected 0", bus.outValid); end
        checks++; if (bus.rbTrigger !== 1'b0 || bus.rbAddr !== 4'd0) begin errors++; $display("FAIL reset_rb: got trig %b addr %h expected 0 0", bus.rbTrigger, bus.rbAddr); end
        checks++; if ({bus.opA, bus.opB, bus.opC} !== 96'd0) begin errors++; $display("FAIL reset_ops: got %h %h %h expected 0", bus.opA, bus.opB, bus.opC); end
        checks++; if (bus.instrOut !== 32'd0 || bus.pcOut !== 32'd0) begin errors++; $display("FAIL reset_latched: got %h %h expected 0 0", bus.instrOut, bus.pcOut); end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_full_fetch;
        int cyc;
        bank_mem[1] = 32'd2; bank_mem[2] = 32'd3; bank_mem[3] = 32'd4;
        send(32'h1234_5678, 32'h40, 4'd1, 4'd2, 4'd3, 3'b111, cyc);
        checks++; if (cyc !== 14) begin errors++; $display("FAIL full_cycle: got %0d expected 14", cyc); end
        checks++; if (bus.opA !== 32'd2 || bus.opB !== 32'd3 || bus.opC !== 32'd4) begin errors++; $display("FAIL full_ops: got %h %h %h expected 2 3 4", bus.opA, bus.opB, bus.opC); end
        checks++; if (trig_log.size() !== 3) begin errors++; $display("FAIL full_toggles: got %0d expected 3", trig_log.size()); end
        else begin
            checks++; if (trig_log[0] !== 4'd1 || trig_log[1] !== 4'd2 || trig_log[2] !== 4'd3) begin errors++; $display("FAIL full_addrs: got %h %h %h expected 1 2 3", trig_log[0], trig_log[1], trig_log[2]); end
        end
        consume();
        checks++; if (bus.outValid !== 1'b0 || bus.inReady !== 1'b1) begin errors++; $display("FAIL full_handshake: got outValid %b inReady %b expected 0 1", bus.outValid, bus.inReady); end
    endtask

    task automatic test_pc_bypass;
        int cyc;
        bank_mem[0] = 32'd1;
        send(32'hAAAA_0000, 32'h100, 4'd15, 4'd0, 4'd7, 3'b011, cyc);
        checks++; if (cyc !== 7) begin errors++; $display("FAIL pc_cycle: got %0d expected 7", cyc); end
        checks++; if (bus.opA !== 32'h108 || bus.opB !== 32'd1 || bus.opC !== 32'd0) begin errors++; $display("FAIL pc_ops: got %h %h %h expected 108 1 0", bus.opA, bus.opB, bus.opC); end
        checks++; if (trig_log.size() !== 1 || trig_log[0] !== 4'd0) begin errors++; $display("FAIL pc_toggles: got %0d toggles expected one to addr 0", trig_log.size()); end
        consume();
    endtask

    task automatic test_unused;
        int cyc;
        send(32'hE1A0_0000, 32'h200, 4'd1, 4'd2, 4'd3, 3'b000, cyc);
        checks++; if (cyc !== 2) begin errors++; $display("FAIL unused_cycle: got %0d expected 2", cyc); end
        checks++; if ({bus.opA, bus.opB, bus.opC} !== 96'd0) begin errors++; $display("FAIL unused_ops: got %h %h %h expected 0", bus.opA, bus.opB, bus.opC); end
        checks++; if (bus.instrOut !== 32'hE1A0_0000 || bus.pcOut !== 32'h200) begin errors++; $display("FAIL unused_latched: got %h %h expected e1a00000 200", bus.instrOut, bus.pcOut); end
        checks++; if (trig_log.size() !== 0) begin errors++; $display("FAIL unused_toggles: got %0d expected 0", trig_log.size()); end
        consume();
    endtask

    task automatic test_slow_bank;
        int cyc;
        bank_mem[4] = 32'hCAFE_F00D;
        bank_delay = 10;
        send(32'h0, 32'h300, 4'd4, 4'd0, 4'd0, 3'b001, cyc);
        bank_delay = 0;
        // Ready rises 1 ns after edge 11, is synchronised by edge 13, captured on edge 14.
        checks++; if (cyc !== 16) begin errors++; $display("FAIL slow_cycle: got %0d expected 16", cyc); end
        checks++; if (bus.opA !== 32'hCAFE_F00D) begin errors++; $display("FAIL slow_opA: got %h expected cafef00d", bus.opA); end
        consume();
    endtask

    task automatic test_backpressure;
        int cyc;
        bank_mem[9] = 32'h99;
        send(32'h5555_AAAA, 32'h2000, 4'd9, 4'd3, 4'd15, 3'b101, cyc);
        checks++; if (cyc !== 7) begin errors++; $display("FAIL bp_cycle: got %0d expected 7", cyc); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.outValid !== 1'b1 || bus.inReady !== 1'b0 || bus.opA !== 32'h99 || bus.opB !== 32'd0 ||
                bus.opC !== 32'h2008 || bus.instrOut !== 32'h5555_AAAA || bus.pcOut !== 32'h2000) begin
                errors++;
                $display("FAIL bp_hold%0d: got v%b r%b %h %h %h %h %h expected v1 r0 99 0 2008 5555aaaa 2000",
                         i, bus.outValid, bus.inReady, bus.opA, bus.opB, bus.opC, bus.instrOut, bus.pcOut);
            end
            @(negedge clk);
        end
        consume();
        checks++; if (bus.inReady !== 1'b1) begin errors++; $display("FAIL bp_release: got inReady %b expected 1", bus.inReady); end
    endtask

    task automatic test_reset_mid_wait;
        int cyc;
        bank_mem[5] = 32'h55; bank_mem[6] = 32'h66; bank_mem[7] = 32'h77;
        @(negedge clk);
        bus.rnAddr = 4'd5; bus.rmAddr = 4'd6; bus.rsAddr = 4'd7;
        bus.useMask = 3'b111; bus.pcIn = 32'h400; bus.instrIn = 32'h1;
        bus.inValid = 1'b1;
        @(posedge clk);
        #1 bus.inValid = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.inReady !== 1'b1 || bus.outValid !== 1'b0 || bus.rbTrigger !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: got inReady %b outValid %b trig %b expected 1 0 0", bus.inReady, bus.outValid, bus.rbTrigger); end
        checks++; if ({bus.opA, bus.opB, bus.opC} !== 96'd0) begin errors++; $display("FAIL midrst_ops: got %h %h %h expected 0", bus.opA, bus.opB, bus.opC); end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send(32'h2, 32'h500, 4'd5, 4'd7, 4'd6, 3'b110, cyc);
        checks++; if (cyc !== 10) begin errors++; $display("FAIL midrst_cycle: got %0d expected 10", cyc); end
        checks++; if (bus.opA !== 32'd0 || bus.opB !== 32'h77 || bus.opC !== 32'h66) begin errors++; $display("FAIL midrst_refetch: got %h %h %h expected 0 77 66", bus.opA, bus.opB, bus.opC); end
        consume();
    endtask

    task automatic test_random;
        int          cyc;
        int          ecyc;
        logic [31:0] ea, eb, ec, instr, pc;
        logic [3:0]  rn, rm, rs;
        logic [2:0]  mask;
        for (int k = 0; k < 16; k++) bank_mem[k] = $urandom;
        for (int it = 0; it < 24; it++) begin
            instr = $urandom;
            pc    = (it == 0) ? 32'hFFFF_FFFC : $urandom;
            rn    = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            rm    = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            rs    = ($urandom_range(0, 3) == 0) ? 4'd15 : rn;
            mask  = 3'($urandom_range(0, 7));
            model(pc, rn, rm, rs, mask, ea, eb, ec, ecyc);
            send(instr, pc, rn, rm, rs, mask, cyc);
            checks++; if (cyc !== ecyc) begin errors++; $display("FAIL rand%0d_cycle: got %0d expected %0d", it, cyc, ecyc); end
            checks++; if (bus.opA !== ea || bus.opB !== eb || bus.opC !== ec) begin errors++; $display("FAIL rand%0d_ops: got %h %h %h expected %h %h %h", it, bus.opA, bus.opB, bus.opC, ea, eb, ec); end
            checks++; if (bus.instrOut !== instr || bus.pcOut !== pc) begin errors++; $display("FAIL rand%0d_latched: got %h %h expected %h %h", it, bus.instrOut, bus.pcOut, instr, pc); end
            checks++; if (trig_log != exp_addr) begin errors++; $display("FAIL rand%0d_reads: got %0d reads expected %0d", it, trig_log.size(), exp_addr.size()); end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            consume();
        end
    endtask

    initial begin
        bus.inValid  = 1'b0;
        bus.instrIn  = '0;
        bus.pcIn     = '0;
        bus.rnAddr   = '0;
        bus.rmAddr   = '0;
        bus.rsAddr   = '0;
        bus.useMask  = '0;
        bus.rbReady  = 1'b1;
        bus.rbData   = '0;
        bus.outReady = 1'b0;
        for (int k = 0; k < 16; k++) bank_mem[k] = $urandom;
        test_reset();
        test_full_fetch();
        test_pc_bypass();
        test_unused();
        test_slow_bank();
        test_backpressure();
        test_reset_mid_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
